// File: rtl/lsu_subword_ctrl.sv
// Load/store unit sub-word controller for an RV32I MEM stage.
// Word loads and stores go straight to a word-wide data memory. Byte and
// halfword stores are done as read-modify-write: the IDLE cycle reads the
// old word and merges the new lane into it, and the MERGE_WR cycle writes
// the merged word back. Misaligned, illegal and out-of-range accesses
// raise a one-cycle fault pulse instead of touching memory.
module lsu_subword_ctrl #(
    parameter int DM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        fault,
    output logic [31:0] A,
    output logic        WE_dm,
    output logic [31:0] WD_dm,
    input  logic [31:0] RD_dm
);

    localparam logic [31:0] DEPTH_WORDS = 32'(DM_DEPTH);

    typedef enum logic {
        IDLE     = 1'b0,
        MERGE_WR = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] merge_word;
    logic [31:0] merge_addr;
    logic        drop_pending;

    logic [31:0] word_idx;
    logic        funct_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        bad_access;
    logic        accept;
    logic        do_load;
    logic        do_sw;
    logic        do_sub;
    logic        do_fault;
    logic        in_merge;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Classify the request presented this cycle; only IDLE cycles that are
    // not swallowing the replayed store after a merge accept anything.
    always_comb begin
        word_idx = {2'b00, addr[31:2]};
        if (mem_we) begin
            funct_ok = (funct3 == 3'd0) || (funct3 == 3'd1) || (funct3 == 3'd2);
        end else begin
            funct_ok = (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7);
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        out_of_range = (word_idx >= DEPTH_WORDS);
        bad_access   = !funct_ok || misaligned || out_of_range;
        accept       = rst && (state == IDLE) && mem_req && !drop_pending;
        do_load      = accept && !bad_access && !mem_we;
        do_sw        = accept && !bad_access && mem_we && (funct3 == 3'd2);
        do_sub       = accept && !bad_access && mem_we && (funct3 != 3'd2);
        do_fault     = accept && bad_access;
    end

    // Extract and extend the load lane, and build the merged store word.
    always_comb begin
        case (addr[1:0])
            2'b00:   lane_byte = RD_dm[7:0];
            2'b01:   lane_byte = RD_dm[15:8];
            2'b10:   lane_byte = RD_dm[23:16];
            default: lane_byte = RD_dm[31:24];
        endcase
        lane_half = addr[1] ? RD_dm[31:16] : RD_dm[15:0];
        case (funct3)
            3'd0:    load_val = {{24{lane_byte[7]}}, lane_byte};
            3'd1:    load_val = {{16{lane_half[15]}}, lane_half};
            3'd2:    load_val = RD_dm;
            3'd4:    load_val = {24'd0, lane_byte};
            3'd5:    load_val = {16'd0, lane_half};
            default: load_val = 32'd0;
        endcase
        merged = RD_dm;
        if (funct3[1:0] == 2'b00) begin
            case (addr[1:0])
                2'b00:   merged[7:0]   = wdata[7:0];
                2'b01:   merged[15:8]  = wdata[7:0];
                2'b10:   merged[23:16] = wdata[7:0];
                default: merged[31:24] = wdata[7:0];
            endcase
        end else if (addr[1]) begin
            merged[31:16] = wdata[15:0];
        end else begin
            merged[15:0] = wdata[15:0];
        end
    end

    // Memory-side outputs: the merge cycle replays the registered word,
    // otherwise a word store goes straight through.
    always_comb begin
        in_merge = rst && (state == MERGE_WR);
        stall    = do_sub;
        WE_dm    = in_merge || do_sw;
        A        = in_merge ? merge_addr : word_idx;
        WD_dm    = in_merge ? merge_word : wdata;
    end

    // State machine plus the registered load result and fault pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            merge_word   <= 32'd0;
            merge_addr   <= 32'd0;
            drop_pending <= 1'b0;
            rdata        <= 32'd0;
            rdata_valid  <= 1'b0;
            fault        <= 1'b0;
        end else begin
            rdata_valid <= do_load;
            fault       <= do_fault;
            if (do_load) begin
                rdata <= load_val;
            end else if (do_fault) begin
                rdata <= 32'd0;
            end
            case (state)
                IDLE: begin
                    drop_pending <= 1'b0;
                    if (do_sub) begin
                        merge_word <= merged;
                        merge_addr <= word_idx;
                        state      <= MERGE_WR;
                    end
                end
                default: begin
                    drop_pending <= 1'b1;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Self-checking bench for lsu_subword_ctrl: a behavioural reference model
// predicts every cycle, memory-side outputs are checked mid-cycle and the
// registered results go through a scoreboard queue.
module tb_lsu_subword_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        fault;
    logic [31:0] A;
    logic        WE_dm;
    logic [31:0] WD_dm;
    logic [31:0] RD_dm;

    typedef struct {
        logic        valid;
        logic        flt;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] tb_mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        ref_state;
    logic        ref_drop;
    logic [31:0] ref_merge_word;
    logic [31:0] ref_merge_addr;
    logic [31:0] ref_rdata;
    int          num_checks;
    int          num_fails;

    lsu_subword_ctrl #(.DM_DEPTH(1024)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .fault       (fault),
        .A           (A),
        .WE_dm       (WE_dm),
        .WD_dm       (WD_dm),
        .RD_dm       (RD_dm)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, reads 0 while writing.
    always_comb begin
        if (WE_dm) RD_dm = 32'd0;
        else if (A < 32'd1024) RD_dm = tb_mem[A[9:0]];
        else RD_dm = 32'hDEADBEEF;
    end

    // Data memory write port.
    always @(posedge clk) begin
        if (WE_dm && (A < 32'd1024)) tb_mem[A[9:0]] <= WD_dm;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        int sh;
        if (f3[1:0] == 2'b00) begin
            sh = int'(a[1:0]) * 8;
            v = (w >> sh) & 32'h000000FF;
            if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
        end else if (f3[1:0] == 2'b01) begin
            sh = int'(a[1]) * 16;
            v = (w >> sh) & 32'h0000FFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // Drive one cycle of stimulus, predict it, check it.
    task automatic apply_stimulus(input logic req, input logic we, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd);
        logic        exp_stall;
        logic        exp_we;
        logic [31:0] exp_a;
        logic [31:0] exp_wd;
        exp_t        e;
        exp_t        got;
        logic        f3_ok;
        logic        bad;
        logic [31:0] nbytes;
        logic [31:0] w;
        logic [31:0] m;
        int          sh;
        exp_stall = 1'b0;
        exp_we    = 1'b0;
        exp_a     = 32'd0;
        exp_wd    = 32'd0;
        e.valid   = 1'b0;
        e.flt     = 1'b0;
        e.data    = ref_rdata;
        if (ref_state) begin
            exp_we = 1'b1;
            exp_a  = ref_merge_addr;
            exp_wd = ref_merge_word;
            ref_mem[ref_merge_addr[9:0]] = ref_merge_word;
            ref_state = 1'b0;
            ref_drop  = 1'b1;
        end else if (!req || ref_drop) begin
            ref_drop = 1'b0;
        end else begin
            f3_ok  = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            nbytes = (f3[1:0] == 2'b00) ? 32'd1 : (f3[1:0] == 2'b01) ? 32'd2 : 32'd4;
            bad    = !f3_ok || ((a & (nbytes - 32'd1)) != 32'd0) || ((a >> 2) >= 32'd1024);
            if (bad) begin
                e.flt  = 1'b1;
                e.data = 32'd0;
            end else begin
                w = ref_mem[a[11:2]];
                if (!we) begin
                    e.valid = 1'b1;
                    e.data  = ref_load(f3, a, w);
                end else if (f3 == 3'd2) begin
                    exp_we = 1'b1;
                    exp_a  = a >> 2;
                    exp_wd = wd;
                    ref_mem[a[11:2]] = wd;
                end else begin
                    exp_stall = 1'b1;
                    sh = (f3 == 3'd0) ? int'(a[1:0]) * 8 : int'(a[1]) * 16;
                    m  = ((f3 == 3'd0) ? 32'h000000FF : 32'h0000FFFF) << sh;
                    ref_merge_word = (w & ~m) | ((wd << sh) & m);
                    ref_merge_addr = a >> 2;
                    ref_state = 1'b1;
                end
            end
        end
        ref_rdata = e.data;
        mem_req = req;
        mem_we  = we;
        funct3  = f3;
        addr    = a;
        wdata   = wd;
        @(negedge clk);
        check_output("stall", 32'(stall), 32'(exp_stall));
        check_output("we_dm", 32'(WE_dm), 32'(exp_we));
        if (exp_we) begin
            check_output("a_dm", A, exp_a);
            check_output("wd_dm", WD_dm, exp_wd);
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_output("sb_size", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            check_output("rdata_valid", 32'(rdata_valid), 32'(got.valid));
            check_output("fault", 32'(fault), 32'(got.flt));
            check_output("rdata", rdata, got.data);
        end
    endtask

    initial begin
        num_checks = 0;
        num_fails  = 0;
        ref_state  = 1'b0;
        ref_drop   = 1'b0;
        ref_rdata  = 32'd0;
        ref_merge_word = 32'd0;
        ref_merge_addr = 32'd0;
        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]  = 32'd0;
            ref_mem[i] = 32'd0;
        end
        tb_mem[40]   = 32'h00000006;  ref_mem[40]   = 32'h00000006;
        tb_mem[41]   = 32'h8899AABB;  ref_mem[41]   = 32'h8899AABB;
        tb_mem[1023] = 32'hCAFEF00D;  ref_mem[1023] = 32'hCAFEF00D;

        // Reset with a word store presented: nothing may reach memory.
        rst     = 1'b0;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        funct3  = 3'd2;
        addr    = 32'h000000A0;
        wdata   = 32'h00000055;
        #12;
        check_output("rst_we_dm", 32'(WE_dm), 32'd0);
        check_output("rst_stall", 32'(stall), 32'd0);
        check_output("rst_rdata", rdata, 32'd0);
        check_output("rst_valid", 32'(rdata_valid), 32'd0);
        check_output("rst_fault", 32'(fault), 32'd0);
        @(posedge clk);
        #1;
        check_output("rst_mem40", tb_mem[40], 32'h00000006);
        mem_req = 1'b0;
        rst     = 1'b1;

        // Idle, word load, byte store with replay, loads of the merged word.
        apply_stimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 3'd2, 32'h000000A0, 32'h0);
        check_output("lw_a0", rdata, 32'h00000006);
        apply_stimulus(1'b1, 1'b1, 3'd0, 32'h000000A1, 32'h000000F0);
        apply_stimulus(1'b1, 1'b1, 3'd0, 32'h000000A1, 32'h000000F0);
        apply_stimulus(1'b1, 1'b1, 3'd0, 32'h000000A1, 32'h000000F0);
        apply_stimulus(1'b1, 1'b0, 3'd0, 32'h000000A1, 32'h0);
        check_output("lb_a1", rdata, 32'hFFFFFFF0);
        apply_stimulus(1'b1, 1'b0, 3'd4, 32'h000000A1, 32'h0);
        check_output("lbu_a1", rdata, 32'h000000F0);
        apply_stimulus(1'b1, 1'b0, 3'd1, 32'h000000A0, 32'h0);
        check_output("lh_a0", rdata, 32'hFFFFF006);

        // Misaligned and out-of-range faults.
        apply_stimulus(1'b1, 1'b0, 3'd1, 32'h000000A1, 32'h0);
        apply_stimulus(1'b1, 1'b1, 3'd2, 32'h000000A2, 32'h12345678);
        apply_stimulus(1'b1, 1'b0, 3'd2, 32'h00001000, 32'h0);

        // Lane extraction across a patterned word.
        apply_stimulus(1'b1, 1'b0, 3'd0, 32'h000000A7, 32'h0);
        apply_stimulus(1'b1, 1'b0, 3'd5, 32'h000000A6, 32'h0);
        apply_stimulus(1'b1, 1'b0, 3'd1, 32'h000000A4, 32'h0);
        apply_stimulus(1'b1, 1'b0, 3'd4, 32'h000000A5, 32'h0);

        // Upper halfword store: only the low half of wdata is used.
        apply_stimulus(1'b1, 1'b1, 3'd1, 32'h000000A6, 32'hDEAD1234);
        apply_stimulus(1'b1, 1'b1, 3'd1, 32'h000000A6, 32'hDEAD1234);
        apply_stimulus(1'b1, 1'b1, 3'd1, 32'h000000A6, 32'hDEAD1234);
        apply_stimulus(1'b1, 1'b0, 3'd2, 32'h000000A4, 32'h0);
        check_output("lw_a4_merged", rdata, 32'h1234AABB);

        // Last legal word, then illegal encodings.
        apply_stimulus(1'b1, 1'b0, 3'd2, 32'h00000FFC, 32'h0);
        apply_stimulus(1'b1, 1'b1, 3'd2, 32'h00000FFC, 32'h11223344);
        apply_stimulus(1'b1, 1'b0, 3'd2, 32'h00000FFC, 32'h0);
        apply_stimulus(1'b1, 1'b0, 3'd3, 32'h000000A0, 32'h0);
        apply_stimulus(1'b1, 1'b1, 3'd4, 32'h000000A0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 3'd6, 32'h000000A0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 3'd2, 32'h000000A4, 32'h0);
        apply_stimulus(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

        // Reset during the merge write abandons the store.
        apply_stimulus(1'b1, 1'b1, 3'd1, 32'h000000A0, 32'h0000BEEF);
        rst       = 1'b0;
        ref_state = 1'b0;
        ref_drop  = 1'b0;
        ref_rdata = 32'd0;
        #1;
        check_output("mrst_we_dm", 32'(WE_dm), 32'd0);
        check_output("mrst_stall", 32'(stall), 32'd0);
        check_output("mrst_rdata", rdata, 32'd0);
        check_output("mrst_valid", 32'(rdata_valid), 32'd0);
        check_output("mrst_fault", 32'(fault), 32'd0);
        @(posedge clk);
        #1;
        check_output("mrst_mem40", tb_mem[40], 32'h0000F006);
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b0, 3'd2, 32'h000000A0, 32'h0);
        check_output("lw_after_rst", rdata, 32'h0000F006);
        mem_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/lsu_subword_ctrl.md
LSU_SUBWORD_CTRL -- requirements
Module: lsu_subword_ctrl

Interface
REQ-001 Parameter DM_DEPTH, default 1024: number of 32-bit words in the downstream data memory; word indices >= DM_DEPTH SHALL be faulted.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-004 mem_req  input  1  MEM-stage access valid this cycle.
REQ-005 mem_we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  RV32I width/sign code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
REQ-007 addr  input  32  byte address from the ALU.
REQ-008 wdata  input  32  store data; the low byte or halfword is used for SB/SH.
REQ-009 stall  output  1  holds the pipeline for one cycle during a sub-word store.
REQ-010 rdata  output  32  registered, extended load result for MEM/WB.
REQ-011 rdata_valid  output  1  registered; 1 for the one cycle rdata carries a load result.
REQ-012 fault  output  1  registered one-cycle pulse on a misaligned, illegal or out-of-range access.
REQ-013 A  output  32  word index to data memory, {2'b00, addr[31:2]}.
REQ-014 WE_dm  output  1  data memory write enable.
REQ-015 WD_dm  output  32  data memory write word.
REQ-016 RD_dm  input  32  combinational data memory read word; reads 0 while WE_dm=1.

Function
REQ-017 FSM states: IDLE and MERGE_WR; reset state is IDLE.
REQ-018 IDLE, no mem_req: WE_dm=0, stall=0, rdata_valid=0 next cycle, rdata holds its value.
REQ-019 IDLE, legal load: WE_dm=0 and RD_dm sampled the same cycle; next cycle rdata_valid=1 (latency 1, no stall).
REQ-020 Load extraction: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes RD_dm unchanged.
REQ-021 IDLE, legal SW: WE_dm=1 and WD_dm=wdata the same cycle; no stall; state stays IDLE.
REQ-022 IDLE, legal SB/SH: WE_dm=0, stall=1, RD_dm sampled; merged word (wdata lane replacing the addressed byte or half, other bytes kept) and A are registered; next state MERGE_WR.
REQ-023 MERGE_WR: WE_dm=1, A and WD_dm from the registered values, stall=0; next state IDLE unconditionally.
REQ-024 Inputs SHALL be ignored in MERGE_WR; the pipeline presents the same store again after the stall and it SHALL be dropped once (one-shot flag set in MERGE_WR, cleared after one IDLE cycle).
REQ-025 Misaligned accesses: any access with addr[1:0]!=0 for LW/SW, or addr[0]=1 for LH/LHU/SH.
REQ-026 Illegal funct3: 3, 6 or 7 for loads; any value other than 0, 1 or 2 for stores.
REQ-027 Misaligned, illegal and out-of-range (addr[31:2] >= DM_DEPTH) accesses: WE_dm=0, no stall, next cycle fault=1, rdata=0 and rdata_valid=0.
REQ-028 WE_dm SHALL never be 1 in the same cycle as a load sample.
REQ-029 At most one outstanding access exists; there is no buffering beyond the one merged word.

Reset
REQ-030 rst=0 SHALL immediately force state=IDLE, stall=0, WE_dm=0, rdata=0, rdata_valid=0, fault=0, and clear the merge register and the one-shot flag.
REQ-031 Reset asserted in MERGE_WR SHALL abandon the write; memory is left unchanged.
REQ-032 The first access after rst rises SHALL be serviced normally in IDLE.

Verification
REQ-033 Memory word 40 = 0x00000006; LW addr 0xA0 -> next cycle rdata=0x00000006, rdata_valid=1, stall never 1.
REQ-034 SB wdata=0x000000F0 addr 0xA1 -> stall=1 for one cycle, then WE_dm=1, A=40, WD_dm=0x0000F006; the repeated request is dropped.
REQ-035 After REQ-034: LB 0xA1 -> rdata=0xFFFFFFF0; LBU 0xA1 -> 0x000000F0; LH 0xA0 -> 0xFFFFF006.
REQ-036 LH addr 0xA1, then SW addr 0xA2, then LW addr 0x1000 (DM_DEPTH=1024) -> fault pulses each cycle, WE_dm stays 0, rdata_valid=0.
REQ-037 SH addr 0xA0, rst=0 during MERGE_WR -> WE_dm never 1; word 40 unchanged; outputs at reset values.
